// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back pipeline register and forwarding integer register file
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int EX_FWD_EN  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [31:0]           inst_i,
  input  logic                  reg_we_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic [4:0]            raddr1_i,
  input  logic [4:0]            raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [31:0]           commit_cnt_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic                  wb_we_q;
  logic [4:0]            wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [31:0]           commit_cnt_q;

  logic [4:0] ex_rd;
  logic       ex_fwd_ok;
  logic       unused_inst;

  assign ex_rd       = inst_i[11:7];
  assign unused_inst = ^{inst_i[31:12], inst_i[6:0]};
  assign ex_fwd_ok   = (EX_FWD_EN != 0) && reg_we_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      commit_cnt_q <= '0;
    end else begin
      if (wb_we_q) begin
        regs_q[wb_rd_q] <= wb_data_q;
        commit_cnt_q    <= commit_cnt_q + 32'd1;
      end
      if (flush_i) begin
        wb_we_q   <= 1'b0;
        wb_rd_q   <= '0;
        wb_data_q <= '0;
      end else if (hold_i) begin
        // the held write has just committed on this edge; don't commit it again
        wb_we_q <= 1'b0;
      end else begin
        wb_we_q   <= reg_we_i && (ex_rd != 5'd0);
        wb_rd_q   <= ex_rd;
        wb_data_q <= reg_wdata_i;
      end
    end
  end

  // newest value wins: execute, then write-back, then the array
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == 5'd0) begin
      rdata1_o = '0;
    end else if (ex_fwd_ok && ex_rd == raddr1_i) begin
      rdata1_o = reg_wdata_i;
    end else if (wb_we_q && wb_rd_q == raddr1_i) begin
      rdata1_o = wb_data_q;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == 5'd0) begin
      rdata2_o = '0;
    end else if (ex_fwd_ok && ex_rd == raddr2_i) begin
      rdata2_o = reg_wdata_i;
    end else if (wb_we_q && wb_rd_q == raddr2_i) begin
      rdata2_o = wb_data_q;
    end
  end

  assign wb_valid_o   = wb_we_q;
  assign wb_rd_o      = wb_rd_q;
  assign commit_cnt_o = commit_cnt_q;

endmodule
